// File: rtl/psum_accum_quant.sv
// -----------------------------------------------------------------------------
// psum_accum_quant
//   Post-adder-tree stage. Accumulates N signed partial sums per output
//   (one per input-channel group), adds a per-output bias, then
//   round-shifts, optionally applies ReLU and saturates to a signed OUT_W
//   activation. The pipeline has three steps:
//     stage A : group accumulator plus a small IDLE/ACCUM FSM
//     stage B : biased sum with the shift/relu settings latched alongside it
//     stage C : round, ReLU and saturate into the registered outputs
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active-high
//   clr_i         synchronous flush of the group and the pipeline (overrides vld_i)
//   cfg_num_psum  psums per output N (0 is treated as 1), latched at group start
//   cfg_shift     right-shift amount applied after the bias add
//   cfg_relu      1: clamp negative results to 0
//   bias_i        signed bias, sampled together with the last psum of a group
//   vld_i         psum_i valid
//   psum_i        signed partial sum
//   data_o        signed quantised activation, holds while vld_o=0
//   vld_o         one-cycle pulse per completed group
//   ovf_o         sticky flag: a result saturated since reset/clr
//   busy_o        a group is partially accumulated
// -----------------------------------------------------------------------------
module psum_accum_quant #(
    parameter int IN_W   = 20,
    parameter int ACC_W  = 32,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic [CNT_W-1:0]  cfg_num_psum,
    input  logic [4:0]        cfg_shift,
    input  logic              cfg_relu,
    input  logic [BIAS_W-1:0] bias_i,
    input  logic              vld_i,
    input  logic [IN_W-1:0]   psum_i,
    output logic [OUT_W-1:0]  data_o,
    output logic              vld_o,
    output logic              ovf_o,
    output logic              busy_o
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturation bounds of the signed OUT_W result, held at ACC_W+1 bits.
    localparam logic signed [ACC_W:0] SAT_MAX =
        $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    // Clamp to the OUT_W range; the MSB of the return value flags a clamp.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [ACC_W:0] v);
        logic [OUT_W:0] res;
        if (v > SAT_MAX) begin
            res = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (v < SAT_MIN) begin
            res = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            res = {1'b0, v[OUT_W-1:0]};
        end
        return res;
    endfunction

    // Stage A state
    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         nl_q, nl_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    // Stage B state
    logic signed [ACC_W-1:0]  b_sum_q, b_sum_d;
    logic [4:0]               b_shift_q, b_shift_d;
    logic                     b_relu_q, b_relu_d;
    logic                     b_vld_q, b_vld_d;
    // Stage C / output state
    logic [OUT_W-1:0]         data_q, data_d;
    logic                     vld_q, vld_d;
    logic                     ovf_q, ovf_d;

    // Combinational helpers
    logic [CNT_W-1:0]         n_eff_s;
    logic signed [ACC_W-1:0]  psum_ext_s;
    logic signed [ACC_W-1:0]  bias_ext_s;
    logic signed [ACC_W-1:0]  acc_next_s;
    logic                     done_s;
    logic signed [ACC_W:0]    rnd_s;
    logic signed [ACC_W:0]    sum_s;
    logic signed [ACC_W:0]    shifted_s;
    logic signed [ACC_W:0]    relu_s;
    logic [OUT_W:0]           sat_s;

    // Operand extension, effective group length and next accumulator value.
    always_comb begin
        psum_ext_s = $signed({{(ACC_W-IN_W){psum_i[IN_W-1]}}, psum_i});
        bias_ext_s = $signed({{(ACC_W-BIAS_W){bias_i[BIAS_W-1]}}, bias_i});
        if (cfg_num_psum == {CNT_W{1'b0}}) begin
            n_eff_s = CNT_ONE;
        end else begin
            n_eff_s = cfg_num_psum;
        end
        if (state_q == S_IDLE) begin
            acc_next_s = psum_ext_s;
        end else begin
            acc_next_s = acc_q + psum_ext_s;
        end
    end

    // Group-complete detection: last psum of the group is being accepted.
    always_comb begin
        done_s = 1'b0;
        if (vld_i && !clr_i) begin
            case (state_q)
                S_IDLE:  done_s = (n_eff_s == CNT_ONE);
                S_ACCUM: done_s = (cnt_q == (nl_q - CNT_ONE));
                default: done_s = 1'b0;
            endcase
        end else begin
            done_s = 1'b0;
        end
    end

    // Stage A FSM next state and stage B load.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nl_d      = nl_q;
        acc_d     = acc_q;
        b_sum_d   = b_sum_q;
        b_shift_d = b_shift_q;
        b_relu_d  = b_relu_q;
        b_vld_d   = 1'b0;
        if (clr_i) begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            acc_d   = {ACC_W{1'b0}};
        end else if (vld_i) begin
            acc_d = acc_next_s;
            case (state_q)
                S_IDLE: begin
                    nl_d = n_eff_s;
                    if (done_s) begin
                        cnt_d = {CNT_W{1'b0}};
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (done_s) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_IDLE;
                end
            endcase
            if (done_s) begin
                b_sum_d   = acc_next_s + bias_ext_s;
                b_shift_d = cfg_shift;
                b_relu_d  = cfg_relu;
                b_vld_d   = 1'b1;
            end else begin
                b_vld_d   = 1'b0;
            end
        end else begin
            b_vld_d = 1'b0;
        end
    end

    // Stage C datapath: round-half-up shift (one extra bit so the rounding
    // add cannot wrap), then ReLU, then saturation.
    always_comb begin
        if (b_shift_q != 5'd0) begin
            rnd_s = $signed({{ACC_W{1'b0}}, 1'b1} << (b_shift_q - 5'd1));
        end else begin
            rnd_s = {(ACC_W+1){1'b0}};
        end
        sum_s     = $signed({b_sum_q[ACC_W-1], b_sum_q}) + rnd_s;
        shifted_s = sum_s >>> b_shift_q;
        if (b_relu_q && shifted_s[ACC_W]) begin
            relu_s = {(ACC_W+1){1'b0}};
        end else begin
            relu_s = shifted_s;
        end
        sat_s = sat_fn(relu_s);
    end

    // Output register next state; ReLU zeroing never counts as overflow.
    always_comb begin
        data_d = data_q;
        vld_d  = 1'b0;
        ovf_d  = ovf_q;
        if (clr_i) begin
            vld_d = 1'b0;
            ovf_d = 1'b0;
        end else if (b_vld_q) begin
            data_d = sat_s[OUT_W-1:0];
            vld_d  = 1'b1;
            ovf_d  = ovf_q | sat_s[OUT_W];
        end else begin
            vld_d = 1'b0;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            nl_q      <= CNT_ONE;
            acc_q     <= {ACC_W{1'b0}};
            b_sum_q   <= {ACC_W{1'b0}};
            b_shift_q <= 5'd0;
            b_relu_q  <= 1'b0;
            b_vld_q   <= 1'b0;
            data_q    <= {OUT_W{1'b0}};
            vld_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nl_q      <= nl_d;
            acc_q     <= acc_d;
            b_sum_q   <= b_sum_d;
            b_shift_q <= b_shift_d;
            b_relu_q  <= b_relu_d;
            b_vld_q   <= b_vld_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            ovf_q     <= ovf_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;
    assign ovf_o  = ovf_q;
    assign busy_o = (state_q == S_ACCUM);

endmodule

// File: tb/tb_psum_accum_quant.sv
// -----------------------------------------------------------------------------
// tb_psum_accum_quant
//   Directed bench for psum_accum_quant. Outputs are captured on the falling
//   edge into a queue (value plus cycle index) and compared against
//   hand-computed results.
// -----------------------------------------------------------------------------
module tb_psum_accum_quant;

    logic        clk;
    logic        rst;
    logic        clr_i;
    logic [7:0]  cfg_num_psum;
    logic [4:0]  cfg_shift;
    logic        cfg_relu;
    logic [15:0] bias_i;
    logic        vld_i;
    logic [19:0] psum_i;
    logic [7:0]  data_o;
    logic        vld_o;
    logic        ovf_o;
    logic        busy_o;

    int total;
    int bad;
    int cyc;
    int outs[$];
    int out_cyc[$];

    psum_accum_quant dut (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr_i),
        .cfg_num_psum (cfg_num_psum),
        .cfg_shift    (cfg_shift),
        .cfg_relu     (cfg_relu),
        .bias_i       (bias_i),
        .vld_i        (vld_i),
        .psum_i       (psum_i),
        .data_o       (data_o),
        .vld_o        (vld_o),
        .ovf_o        (ovf_o),
        .busy_o       (busy_o)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid output away from the active edge.
    always @(negedge clk) begin
        if (vld_o) begin
            outs.push_back(int'($signed(data_o)));
            out_cyc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int p, input int b);
        logic [31:0] pv;
        logic [31:0] bv;
        pv     = p;
        bv     = b;
        psum_i = pv[19:0];
        bias_i = bv[15:0];
        vld_i  = 1'b1;
        @(posedge clk);
        #1;
        vld_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
        outs.delete();
        out_cyc.delete();
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        cyc          = 0;
        clk          = 1'b0;
        rst          = 1'b1;
        clr_i        = 1'b0;
        cfg_num_psum = 8'd1;
        cfg_shift    = 5'd0;
        cfg_relu     = 1'b0;
        bias_i       = 16'd0;
        vld_i        = 1'b0;
        psum_i       = 20'd0;
        idle(2);
        check_val("rst_data", int'(data_o), 0);
        check_val("rst_vld", int'(vld_o), 0);
        check_val("rst_ovf", int'(ovf_o), 0);
        check_val("rst_busy", int'(busy_o), 0);
        rst = 1'b0;
        idle(1);

        // 1: N=4, 100+200-50+10 = 260 saturates to 127, two-edge latency
        cfg_num_psum = 8'd4;
        cfg_shift    = 5'd0;
        cfg_relu     = 1'b0;
        send(100, 0);
        check_val("t1_busy_mid", int'(busy_o), 1);
        send(200, 0);
        send(-50, 0);
        send(10, 0);
        check_val("t1_vld_early", int'(vld_o), 0);
        check_val("t1_busy_end", int'(busy_o), 0);
        idle(1);
        check_val("t1_vld", int'(vld_o), 1);
        check_val("t1_data", int'($signed(data_o)), 127);
        check_val("t1_ovf", int'(ovf_o), 1);
        idle(1);
        check_val("t1_vld_pulse", int'(vld_o), 0);
        check_val("t1_count", outs.size(), 1);
        flush();
        check_val("t1_ovf_clr", int'(ovf_o), 0);

        // 2: N=2, s=2: (11+2)>>>2=3, (-6+2)>>>2=-1; mid-group N change ignored
        cfg_num_psum = 8'd2;
        cfg_shift    = 5'd2;
        send(5, 0);
        cfg_num_psum = 8'd5;
        send(6, 0);
        cfg_num_psum = 8'd2;
        send(-2, 0);
        send(-4, 0);
        idle(3);
        check_val("t2_count", outs.size(), 2);
        if (outs.size() == 2) begin
            check_val("t2_pos", outs[0], 3);
            check_val("t2_neg", outs[1], -1);
        end else begin
            check_val("t2_outputs", outs.size(), 2);
        end
        check_val("t2_ovf", int'(ovf_o), 0);
        flush();

        // 3: N=1, -300 saturates to -128; ReLU gives 0 without overflow
        cfg_num_psum = 8'd0;
        cfg_shift    = 5'd0;
        cfg_relu     = 1'b0;
        send(-300, 0);
        idle(3);
        check_val("t3_sat_data", int'($signed(data_o)), -128);
        check_val("t3_sat_ovf", int'(ovf_o), 1);
        cfg_relu = 1'b1;
        send(-300, 0);
        idle(3);
        check_val("t3_relu_data", int'($signed(data_o)), 0);
        check_val("t3_relu_ovf_hold", int'(ovf_o), 1);
        flush();
        send(-300, 0);
        idle(3);
        check_val("t3_relu_ovf_clr", int'(ovf_o), 0);
        check_val("t3_relu_count", outs.size(), 1);
        flush();

        // 4: N=1 back-to-back with bias 10 -> 11,12,13 on consecutive cycles
        cfg_relu     = 1'b0;
        cfg_num_psum = 8'd1;
        send(1, 10);
        send(2, 10);
        send(3, 10);
        idle(3);
        check_val("t4_count", outs.size(), 3);
        if (outs.size() == 3) begin
            check_val("t4_d0", outs[0], 11);
            check_val("t4_d1", outs[1], 12);
            check_val("t4_d2", outs[2], 13);
            check_val("t4_gap01", out_cyc[1] - out_cyc[0], 1);
            check_val("t4_gap12", out_cyc[2] - out_cyc[1], 1);
        end else begin
            check_val("t4_outputs", outs.size(), 3);
        end
        flush();

        // 5: N=3, partial group flushed, then 1,1,1 with idle gaps -> 3
        cfg_num_psum = 8'd3;
        send(50, 0);
        send(50, 0);
        flush();
        check_val("t5_busy_clr", int'(busy_o), 0);
        send(1, 0);
        idle(2);
        send(1, 0);
        idle(2);
        send(1, 0);
        idle(3);
        check_val("t5_count", outs.size(), 1);
        if (outs.size() == 1) begin
            check_val("t5_data", outs[0], 3);
        end else begin
            check_val("t5_outputs", outs.size(), 1);
        end
        flush();

        // 6: async reset mid-group, then 1+2+3-16 = -10, (-10+1)>>>1 = -5
        cfg_num_psum = 8'd3;
        cfg_shift    = 5'd1;
        send(7, -16);
        send(7, -16);
        check_val("t6_busy_pre", int'(busy_o), 1);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        check_val("t6_busy_rst", int'(busy_o), 0);
        idle(1);
        send(1, -16);
        send(2, -16);
        send(3, -16);
        idle(3);
        check_val("t6_count", outs.size(), 1);
        if (outs.size() == 1) begin
            check_val("t6_data", outs[0], -5);
        end else begin
            check_val("t6_outputs", outs.size(), 1);
        end
        check_val("t6_ovf", int'(ovf_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
